// File: rtl/clarvi_regfile_parts.sv
// Partitioned Clarvi integer register file: per-part banks, 1-cycle reads, clear-after-reset.
// Optional write-to-read forwarding when CLARVI_REGFILE_BYPASS_EN is defined.
module clarvi_regfile_parts #(
    parameter int XLEN   = 64,
    parameter int PART_W = 32,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    localparam int PARTS = XLEN / PART_W,
    localparam int PW    = (PARTS > 1) ? $clog2(PARTS) : 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                      clock,
    input  logic                      reset,
    output logic                      ready,
    input  logic [NREAD-1:0]          rd_en,
    input  logic [NREAD*AW-1:0]       rd_addr,
    input  logic [NREAD*PW-1:0]       rd_part,
    output logic [NREAD*PART_W-1:0]   rd_data,
    input  logic                      wr_en,
    input  logic [AW-1:0]             wr_addr,
    input  logic [PW-1:0]             wr_part,
    input  logic [PART_W-1:0]         wr_data,
    input  logic [AW-1:0]             dbg_addr,
    output logic [XLEN-1:0]           dbg_data
);

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_e;

    state_e                       state_q, state_d;
    logic [AW-1:0]                clr_idx_q, clr_idx_d;
    logic                         clr_we;
    logic                         wr_we;
    logic [XLEN-1:0]              dbg_data_q, dbg_data_d;
    logic [NREAD*PARTS*PART_W-1:0] rd_word;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        unique case (state_q)
            S_CLEAR: begin
                clr_idx_d = clr_idx_q + AW'(1);
                if (clr_idx_q == AW'(NREGS - 1)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_CLEAR;
            clr_idx_q  <= '0;
            dbg_data_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_idx_q  <= clr_idx_d;
            dbg_data_q <= dbg_data_d;
        end
    end

    assign ready    = (state_q == S_RUN);
    assign clr_we   = (state_q == S_CLEAR);
    assign wr_we    = ready && !reset && wr_en && (wr_addr != '0);
    assign dbg_data = dbg_data_q;

    // One bank per part; a part write never touches the other banks.
    for (genvar p = 0; p < PARTS; p++) begin : g_bank
        logic [PART_W-1:0] mem [NREGS];

        always_ff @(posedge clock) begin
            if (clr_we) begin
                mem[clr_idx_q] <= '0;
            end else if (wr_we && (wr_part == PW'(p))) begin
                mem[wr_addr] <= wr_data;
            end
        end

        assign dbg_data_d[p*PART_W +: PART_W] = (dbg_addr == '0) ? '0 : mem[dbg_addr];

        for (genvar i = 0; i < NREAD; i++) begin : g_port
            assign rd_word[(i*PARTS+p)*PART_W +: PART_W] = mem[rd_addr[i*AW +: AW]];
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0]     addr;
        logic [PW-1:0]     part;
        logic [PART_W-1:0] cand [PARTS];
        logic [PART_W-1:0] data_q, data_d;

        assign addr = rd_addr[i*AW +: AW];
        assign part = rd_part[i*PW +: PW];

        for (genvar p = 0; p < PARTS; p++) begin : g_cand
            assign cand[p] = rd_word[(i*PARTS+p)*PART_W +: PART_W];
        end

        always_comb begin
            data_d = data_q;
            if (rd_en[i]) begin
                if (!ready || (addr == '0)) begin
                    data_d = '0;
`ifdef CLARVI_REGFILE_BYPASS_EN
                end else if (wr_we && (wr_addr == addr) && (wr_part == part)) begin
                    data_d = wr_data;
`endif
                end else begin
                    data_d = cand[part];
                end
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                data_q <= '0;
            end else begin
                data_q <= data_d;
            end
        end

        assign rd_data[i*PART_W +: PART_W] = data_q;
    end

endmodule
